// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one sram-like memory port between the I-cache and
// D-cache. One transaction in flight; each grant walks address phase then data
// phase and the handshakes are routed back to the owning cache only.
// Optional feature: define ARB_RR_EN for round-robin arbitration on ties;
// without it the D-cache always wins over the I-cache.
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic                  inst_wr,
    input  logic [1:0]            inst_size,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [DATA_WIDTH-1:0] inst_wdata,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    output logic                  arb_busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] I_ADDR = 3'd1;
    localparam logic [2:0] D_ADDR = 3'd2;
    localparam logic [2:0] I_DATA = 3'd3;
    localparam logic [2:0] D_DATA = 3'd4;

    logic [2:0] state, state_next;
    logic       pick_d;     // IDLE decision: grant goes to the D-cache
    logic       sel_d;      // current owner is the D-cache
    logic       in_addr;
    logic       in_data;
    logic       active;
    logic       g_req;
    logic       addr_ok_g;
    logic       data_ok_g;

`ifdef ARB_RR_EN
    // last_grant is 1 after an I grant and 0 after a D grant or reset,
    // so the very first tie goes to the I-cache.
    logic last_grant;

    // Tie-break toward the master that did not win last time.
    always_comb begin
        pick_d = data_req;
        if (data_req && inst_req)
            pick_d = last_grant;
    end

    // Remember who won each grant taken out of IDLE.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b0;
        else if (state == IDLE && (inst_req || data_req))
            last_grant <= !pick_d;
    end
`else
    // Fixed priority: the D-cache wins whenever it asks.
    always_comb begin
        pick_d = data_req;
    end
`endif

    // Decode the owner and phase from the state.
    always_comb begin
        sel_d   = (state == D_ADDR) || (state == D_DATA);
        in_addr = (state == I_ADDR) || (state == D_ADDR);
        in_data = (state == I_DATA) || (state == D_DATA);
        active  = !rst && (state != IDLE);
        g_req   = sel_d ? data_req : inst_req;
    end

    // Next-state: grant from IDLE, abort on withdrawn request, fold a
    // same-cycle addr_ok/data_ok straight back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (data_req || inst_req)
                    state_next = pick_d ? D_ADDR : I_ADDR;
            end
            I_ADDR, D_ADDR: begin
                if (!g_req)
                    state_next = IDLE;
                else if (mem_addr_ok)
                    state_next = mem_data_ok ? IDLE : (sel_d ? D_DATA : I_DATA);
            end
            I_DATA, D_DATA: begin
                if (mem_data_ok)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Memory-side request and payload, muxed from the owner; zero when idle.
    always_comb begin
        mem_req   = active && in_addr && g_req;
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (active) begin
            mem_wr    = sel_d ? data_wr    : inst_wr;
            mem_size  = sel_d ? data_size  : inst_size;
            mem_addr  = sel_d ? data_addr  : inst_addr;
            mem_wdata = sel_d ? data_wdata : inst_wdata;
        end
    end

    // Handshakes back to the owner only; the other master never sees one.
    always_comb begin
        addr_ok_g    = mem_req && mem_addr_ok;
        data_ok_g    = active && mem_data_ok && (in_data || addr_ok_g);
        inst_addr_ok = addr_ok_g && !sel_d;
        data_addr_ok = addr_ok_g && sel_d;
        inst_data_ok = data_ok_g && !sel_d;
        data_data_ok = data_ok_g && sel_d;
        arb_busy     = active;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_cache_mem_arbiter;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, arb_busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    cache_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the port (0 none, 1 I, 2 D), whether the
    // address has been accepted, and whose turn a tie is (round-robin only).
    int m_owner  = 0;
    bit m_data   = 1'b0;
    bit m_i_turn = 1'b1;
    bit e_i_aok, e_d_aok;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    // Mid-cycle: compare every output with what the model predicts.
    task automatic mid();
        int own;
        logic gr, e_mreq, e_aok, e_dok, e_wr;
        logic [1:0] e_size;
        logic [31:0] e_addr, e_wdata;
        @(negedge clk);
        own     = rst ? 0 : m_owner;
        gr      = (own == 2) ? data_req : (own == 1) ? inst_req : 1'b0;
        e_mreq  = (own != 0) && !m_data && gr;
        e_aok   = e_mreq && mem_addr_ok;
        e_dok   = (own != 0) && mem_data_ok && (m_data || e_aok);
        e_wr    = (own == 2) ? data_wr    : (own == 1) ? inst_wr    : 1'b0;
        e_size  = (own == 2) ? data_size  : (own == 1) ? inst_size  : 2'd0;
        e_addr  = (own == 2) ? data_addr  : (own == 1) ? inst_addr  : 32'd0;
        e_wdata = (own == 2) ? data_wdata : (own == 1) ? inst_wdata : 32'd0;
        e_i_aok = (own == 1) && e_aok;
        e_d_aok = (own == 2) && e_aok;
        chk("mem_req",      mem_req,      e_mreq);
        chk("mem_wr",       mem_wr,       e_wr);
        chk("mem_size",     mem_size,     e_size);
        chk("mem_addr",     mem_addr,     e_addr);
        chk("mem_wdata",    mem_wdata,    e_wdata);
        chk("arb_busy",     arb_busy,     own != 0);
        chk("inst_addr_ok", inst_addr_ok, e_i_aok);
        chk("data_addr_ok", data_addr_ok, e_d_aok);
        chk("inst_data_ok", inst_data_ok, (own == 1) && e_dok);
        chk("data_data_ok", data_data_ok, (own == 2) && e_dok);
        chk("inst_rdata",   inst_rdata,   mem_rdata);
        chk("data_rdata",   data_rdata,   mem_rdata);
    endtask

    // Clock edge: advance the model with the inputs the DUT also sampled.
    task automatic edge_step();
        logic gr;
        @(posedge clk);
        gr = (m_owner == 2) ? data_req : inst_req;
        if (rst) begin
            m_owner = 0; m_data = 0; m_i_turn = 1;
        end else if (m_owner == 0) begin
            if (inst_req || data_req) begin
                if (inst_req && data_req)
                    m_owner = RR ? (m_i_turn ? 1 : 2) : 2;
                else
                    m_owner = data_req ? 2 : 1;
                m_i_turn = (m_owner == 2);
            end
        end else if (!m_data) begin
            if (!gr) m_owner = 0;
            else if (mem_addr_ok) begin
                if (mem_data_ok) m_owner = 0;
                else m_data = 1;
            end
        end else if (mem_data_ok) begin
            m_owner = 0; m_data = 0;
        end
        #1;
    endtask

    task automatic cyc();
        mid();
        edge_step();
    endtask

    initial begin
        logic [31:0] seq[$];
        int          grants[$];
        int          exp_g[4];
        bit          first_d, i_pend, d_pend;

        // ---- reset ----
        clr(); rst = 1;
        edge_step(); edge_step();
        mid();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_busy", arb_busy, 1'b0);
        edge_step();
        rst = 0;

        // ---- 1: D read alone ----
        data_req = 1; data_addr = 32'h1000; data_size = 2;
        mid(); chk("t1_idle_req", mem_req, 1'b0); edge_step();
        mid(); chk("t1_req", mem_req, 1'b1); chk("t1_addr", mem_addr, 32'h1000); edge_step();
        mem_addr_ok = 1;
        mid(); chk("t1_daok", data_addr_ok, 1'b1); chk("t1_iaok", inst_addr_ok, 1'b0); edge_step();
        data_req = 0; mem_addr_ok = 0;
        mid(); chk("t1_ddok_early", data_data_ok, 1'b0); edge_step();
        mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
        mid();
        chk("t1_ddok", data_data_ok, 1'b1);
        chk("t1_rdata", data_rdata, 32'hDEADBEEF);
        chk("t1_idok", inst_data_ok, 1'b0);
        edge_step();
        clr();
        mid(); chk("t1_idle", arb_busy, 1'b0); edge_step();

        // ---- 2: simultaneous I and D ----
        first_d = !RR;  // round-robin: D went last in test 1, so I wins
        inst_req = 1; inst_addr = 32'hBFC00000;
        data_req = 1; data_addr = 32'h2000;
        cyc();
        mem_addr_ok = 1;
        mid(); seq.push_back(mem_addr); edge_step();
        if (first_d) data_req = 0; else inst_req = 0;
        mem_addr_ok = 0; mem_data_ok = 1;
        cyc();
        mem_data_ok = 0;
        mid(); chk("t2_gap", arb_busy, 1'b0); edge_step();
        mem_addr_ok = 1;
        mid(); seq.push_back(mem_addr); edge_step();
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        cyc();
        clr();
        chk("t2_first",  seq[0], first_d ? 32'h2000 : 32'hBFC00000);
        chk("t2_second", seq[1], first_d ? 32'hBFC00000 : 32'h2000);

        // ---- 3: both requesting continuously ----
        rst = 1; edge_step(); rst = 0;
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        for (int k = 0; k < 8; k++) begin
            mid();
            if (inst_addr_ok) grants.push_back(1);
            if (data_addr_ok) grants.push_back(2);
            edge_step();
        end
        clr();
        if (RR) exp_g = '{1, 2, 1, 2};
        else    exp_g = '{2, 2, 2, 2};
        chk("t3_count", grants.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t3_grant%0d", k), (k < grants.size()) ? grants[k] : 0, exp_g[k]);
        cyc();

        // ---- 4: D write ----
        data_req = 1; data_wr = 1; data_wdata = 32'h12345678; data_size = 2; data_addr = 32'h3000;
        cyc();
        mem_addr_ok = 1;
        mid(); chk("t4_aok", data_addr_ok, 1'b1); edge_step();
        data_req = 0; mem_addr_ok = 0;
        mid();
        chk("t4_wr", mem_wr, 1'b1); chk("t4_wdata", mem_wdata, 32'h12345678);
        chk("t4_size", mem_size, 2'd2); chk("t4_dok_early", data_data_ok, 1'b0);
        edge_step();
        mem_data_ok = 1;
        mid(); chk("t4_wr_last", mem_wr, 1'b1); chk("t4_dok", data_data_ok, 1'b1); edge_step();
        clr();

        // ---- 5: addr_ok and data_ok together ----
        inst_req = 1; inst_addr = 32'h4000;
        cyc();
        mem_addr_ok = 1; mem_data_ok = 1;
        mid(); chk("t5_aok", inst_addr_ok, 1'b1); chk("t5_dok", inst_data_ok, 1'b1); edge_step();
        clr();
        mid(); chk("t5_idle", arb_busy, 1'b0); edge_step();

        // ---- 6: reset while in I_DATA ----
        inst_req = 1; inst_addr = 32'h5000;
        cyc();
        mem_addr_ok = 1; cyc();
        inst_req = 0; mem_addr_ok = 0;
        mid(); chk("t6_busy", arb_busy, 1'b1); edge_step();
        rst = 1; cyc(); rst = 0;
        mid(); chk("t6_busy_after", arb_busy, 1'b0); chk("t6_req_after", mem_req, 1'b0); edge_step();
        mem_data_ok = 1;
        mid(); chk("t6_no_dok", inst_data_ok, 1'b0); edge_step();
        clr();

        // ---- randomized traffic ----
        i_pend = 0; d_pend = 0;
        for (int k = 0; k < 400; k++) begin
            mid();
            edge_step();
            if (i_pend && (e_i_aok || $urandom_range(0, 19) == 0)) i_pend = 0;
            if (d_pend && (e_d_aok || $urandom_range(0, 19) == 0)) d_pend = 0;
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; inst_addr = $urandom; inst_wdata = $urandom;
                inst_wr = 1'($urandom_range(0, 7) == 0); inst_size = 2'($urandom_range(0, 3));
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; data_addr = $urandom; data_wdata = $urandom;
                data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 3));
            end
            inst_req    = i_pend;
            data_req    = d_pend;
            mem_addr_ok = 1'($urandom_range(0, 1));
            mem_data_ok = 1'($urandom_range(0, 2) == 0);
            mem_rdata   = $urandom;
            rst         = 1'($urandom_range(0, 99) == 0);
        end
        rst = 0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
